fp_divsqrt_pool_ctrl: RTL and testbench
=======================================

Name: fp_divsqrt_pool_ctrl

Overview:
Controller for a pool of NUM_UNITS iterative FP div/sqrt units shared by ISSUE_WIDTH FP issue lanes. It generalises the single-unit reserve/request/finish/release handshake to N units and M lanes. It adds per-unit ownership tags, selective-flush cancellation with active-list wrap-around, and result holding until the owning lane releases. It sits between the FP scheduler/FP execution stage and the external div/sqrt datapaths.

Parameters:
ISSUE_WIDTH, 2, number of FP issue lanes that may reserve/request/release
NUM_UNITS, 2, number of div/sqrt datapaths managed (1..4)
DATA_WIDTH, 32, operand/result width
TAG_WIDTH, 6, active-list pointer width; active list holds 2^TAG_WIDTH entries

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  1  backend stall; freezes grant/accept/release
rsv_req  in  ISSUE_WIDTH  lane wants a unit this cycle
rsv_gnt  out  ISSUE_WIDTH  reservation granted (combinational)
rsv_unit  out  ISSUE_WIDTH*2  granted unit index per lane
req_valid  in  ISSUE_WIDTH  lane presents operands to its reserved unit
req_unit  in  ISSUE_WIDTH*2  target unit index
req_tag  in  ISSUE_WIDTH*TAG_WIDTH  active-list pointer of op
req_is_div  in  ISSUE_WIDTH  1=divide, 0=sqrt
req_rm  in  ISSUE_WIDTH*3  resolved rounding mode
req_opa, req_opb  in  ISSUE_WIDTH*DATA_WIDTH  operands
req_ack  out  ISSUE_WIDTH  request accepted
u_start  out  NUM_UNITS  one-cycle start pulse to unit
u_is_div, u_rm, u_opa, u_opb  out  per-unit  registered operation fields
u_kill  out  NUM_UNITS  one-cycle abort pulse
u_done  in  NUM_UNITS  unit result valid pulse
u_result  in  NUM_UNITS*DATA_WIDTH  unit result
u_fflags  in  NUM_UNITS*5  unit exception flags
fin  out  NUM_UNITS  unit holds finished result
fin_data  out  NUM_UNITS*DATA_WIDTH  held result
fin_fflags  out  NUM_UNITS*5  held flags
rel  in  ISSUE_WIDTH  lane releases unit
rel_unit  in  ISSUE_WIDTH*2  unit being released
flush_valid  in  1  recovery flush this cycle
flush_all  in  1  flush every in-flight op
flush_head, flush_tail  in  TAG_WIDTH each  flush range [head, tail)
free_count  out  3  number of FREE units (registered)

Behaviour:
- Per-unit FSM: FREE -> RESERVED (grant) -> BUSY (accepted req) -> FINISHED (u_done) -> FREE (rel).
- Reset: all units FREE. All outputs 0. free_count=NUM_UNITS. Reset mid-operation drops state; no u_kill is issued, because external units are reset by the same rst.
- Grant, combinational from the current state: lanes are scanned in ascending index and each requesting lane takes the lowest-index FREE unit not already granted. No grant while stall. A grant takes effect on the next edge.
- Accept: req_ack[i]=req_valid[i] && !stall && state[req_unit[i]]==RESERVED. On the next edge the unit goes BUSY, latches tag/op/operands, and u_start pulses for exactly that cycle.
  - Request to a non-RESERVED unit: ack=0, no state change.
  - Two lanes targeting the same unit: lowest lane wins.
- Completion: u_done while BUSY -> FINISHED next edge. Result and flags are latched; fin=1 and fin_data is held stable until release. u_done in any other state is ignored and flagged by an assertion.
- Release: rel[i] with state[rel_unit[i]]==FINISHED and !stall -> FREE next edge. Release of a non-FINISHED unit is ignored.
- Flush: a unit's tag is in range if flush_all, or if head<=tail and head<=tag<tail, or if head>tail and (tag>=head || tag<tail). head==tail without flush_all is an empty range. Flush acts regardless of stall.
  - RESERVED in range: impossible because no tag is stored yet, so RESERVED units are freed only by flush_all.
  - BUSY or FINISHED in range: -> FREE next edge; u_kill pulses next cycle for BUSY units.
- Simultaneous events: flush beats u_done (result discarded) and beats accept (ack still 0 for that lane). Release and flush together -> FREE. A unit freed this cycle is not grantable until next cycle.
- free_count updates one cycle after state changes.

Decomposition:
- Shared package FPDivSqrtPoolTypes: unit state enum (FREE/RESERVED/BUSY/FINISHED), unit-index type, FFlags width 5, Rounding_Mode reuse.
- Range-check function shared with existing selective-flush logic.
- One natural sub-module: fp_divsqrt_slot (per-unit FSM plus latches), instantiated NUM_UNITS times. The top holds grant/accept arbitration.

Test Plan:
- Basic flow: lane0 rsv_req -> gnt, unit 0 -> req tag=5, opa=0x40800000, opb=0x40000000 -> u_start one cycle later -> u_done=0x40000000 -> fin=1, data held -> rel -> free_count back to 2.
- Contention: both lanes rsv_req with 2 units free -> lane0 gets unit0, lane1 gets unit1. Repeated with 1 unit free -> only lane0 granted.
- Wrap flush: unit BUSY tag=62, flush head=60, tail=2 -> u_kill next cycle, FREE. A tag=10 unit is unaffected.
- Flush/done collision: u_done and in-range flush in the same cycle -> fin stays 0, unit FREE.
- Stall: stall=1 with rsv_req, req_valid and rel asserted -> no gnt/ack/state change. u_done still captured, and fin rises.
- Reset during BUSY: rst=1 -> all FREE, fin=0, u_start=0, free_count=NUM_UNITS the cycle after.

Source files
------------

// File: rtl/fp_divsqrt_pool_ctrl_pkg.sv
// Shared types for the FP div/sqrt unit pool: unit state, index, flag and
// rounding-mode types, plus the active-list range check used by flush logic.
package fp_divsqrt_pool_ctrl_pkg;

  localparam int FFLAGS_W   = 5;
  localparam int RM_W       = 3;
  localparam int UNIT_IDX_W = 2;
  localparam int MAX_UNITS  = 4;

  typedef logic [RM_W-1:0]       rounding_mode_t;
  typedef logic [FFLAGS_W-1:0]   fflags_t;
  typedef logic [UNIT_IDX_W-1:0] unit_idx_t;

  typedef enum logic [1:0] {
    UNIT_FREE     = 2'd0,
    UNIT_RESERVED = 2'd1,
    UNIT_BUSY     = 2'd2,
    UNIT_FINISHED = 2'd3
  } unit_state_e;

  // True when tag lies in the circular active-list window [head, tail).
  // head == tail is an empty window unless everything is flushed.
  function automatic logic tag_in_range(input logic all,
                                        input int unsigned tag,
                                        input int unsigned head,
                                        input int unsigned tail);
    if (all) return 1'b1;
    if (head <= tail) return (tag >= head) && (tag < tail);
    return (tag >= head) || (tag < tail);
  endfunction

endpackage

// File: rtl/fp_divsqrt_slot.sv
// One pool slot: lifecycle FSM of a single div/sqrt unit together with its
// ownership tag, the operation handed to the unit and the held result.
module fp_divsqrt_slot
  import fp_divsqrt_pool_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  grant,
  input  logic                  accept,
  input  logic                  is_div,
  input  rounding_mode_t        rm,
  input  logic [DATA_WIDTH-1:0] opa,
  input  logic [DATA_WIDTH-1:0] opb,
  input  logic [TAG_WIDTH-1:0]  tag,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] result,
  input  fflags_t               fflags,
  input  logic                  rel_hit,
  input  logic                  flush_valid,
  input  logic                  flush_all,
  input  logic [TAG_WIDTH-1:0]  flush_head,
  input  logic [TAG_WIDTH-1:0]  flush_tail,
  output unit_state_e           state,
  output logic                  start,
  output logic                  kill,
  output logic                  fin,
  output logic [DATA_WIDTH-1:0] fin_data,
  output fflags_t               fin_fflags,
  output logic                  op_is_div,
  output rounding_mode_t        op_rm,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b
);

  logic [TAG_WIDTH-1:0] tag_q;
  logic                 tag_hit;

  // Only BUSY/FINISHED consult this; a RESERVED slot has no tag yet.
  assign tag_hit = flush_valid &&
                   tag_in_range(flush_all, 32'(tag_q), 32'(flush_head), 32'(flush_tail));

  // Slot FSM: flush dominates completion, acceptance and release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= UNIT_FREE;
      start      <= 1'b0;
      kill       <= 1'b0;
      fin        <= 1'b0;
      tag_q      <= '0;
      op_is_div  <= 1'b0;
      op_rm      <= '0;
      op_a       <= '0;
      op_b       <= '0;
      fin_data   <= '0;
      fin_fflags <= '0;
    end else begin
      start <= 1'b0;
      kill  <= 1'b0;
      case (state)
        UNIT_FREE: begin
          if (grant) state <= UNIT_RESERVED;
        end
        UNIT_RESERVED: begin
          if (flush_valid && flush_all) begin
            state <= UNIT_FREE;
          end else if (accept) begin
            state     <= UNIT_BUSY;
            start     <= 1'b1;
            tag_q     <= tag;
            op_is_div <= is_div;
            op_rm     <= rm;
            op_a      <= opa;
            op_b      <= opb;
          end
        end
        UNIT_BUSY: begin
          if (tag_hit) begin
            state <= UNIT_FREE;
            kill  <= 1'b1;
          end else if (done) begin
            state      <= UNIT_FINISHED;
            fin        <= 1'b1;
            fin_data   <= result;
            fin_fflags <= fflags;
          end
        end
        UNIT_FINISHED: begin
          if (tag_hit || rel_hit) begin
            state <= UNIT_FREE;
            fin   <= 1'b0;
          end
        end
        default: state <= UNIT_FREE;
      endcase
    end
  end

  // A unit must only report completion while it owns an operation.
  a_done_only_busy: assert property (@(posedge clk) disable iff (rst)
    done |-> (state == UNIT_BUSY));

endmodule

// File: rtl/fp_divsqrt_pool_ctrl.sv
// Pool controller: arbitrates reservations, operand hand-off and releases
// from several FP issue lanes onto NUM_UNITS shared div/sqrt units.
module fp_divsqrt_pool_ctrl
  import fp_divsqrt_pool_ctrl_pkg::*;
#(
  parameter int ISSUE_WIDTH = 2,
  parameter int NUM_UNITS   = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              stall,
  input  logic [ISSUE_WIDTH-1:0]            rsv_req,
  output logic [ISSUE_WIDTH-1:0]            rsv_gnt,
  output logic [ISSUE_WIDTH*UNIT_IDX_W-1:0] rsv_unit,
  input  logic [ISSUE_WIDTH-1:0]            req_valid,
  input  logic [ISSUE_WIDTH*UNIT_IDX_W-1:0] req_unit,
  input  logic [ISSUE_WIDTH*TAG_WIDTH-1:0]  req_tag,
  input  logic [ISSUE_WIDTH-1:0]            req_is_div,
  input  logic [ISSUE_WIDTH*RM_W-1:0]       req_rm,
  input  logic [ISSUE_WIDTH*DATA_WIDTH-1:0] req_opa,
  input  logic [ISSUE_WIDTH*DATA_WIDTH-1:0] req_opb,
  output logic [ISSUE_WIDTH-1:0]            req_ack,
  output logic [NUM_UNITS-1:0]              u_start,
  output logic [NUM_UNITS-1:0]              u_is_div,
  output logic [NUM_UNITS*RM_W-1:0]         u_rm,
  output logic [NUM_UNITS*DATA_WIDTH-1:0]   u_opa,
  output logic [NUM_UNITS*DATA_WIDTH-1:0]   u_opb,
  output logic [NUM_UNITS-1:0]              u_kill,
  input  logic [NUM_UNITS-1:0]              u_done,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0]   u_result,
  input  logic [NUM_UNITS*FFLAGS_W-1:0]     u_fflags,
  output logic [NUM_UNITS-1:0]              fin,
  output logic [NUM_UNITS*DATA_WIDTH-1:0]   fin_data,
  output logic [NUM_UNITS*FFLAGS_W-1:0]     fin_fflags,
  input  logic [ISSUE_WIDTH-1:0]            rel,
  input  logic [ISSUE_WIDTH*UNIT_IDX_W-1:0] rel_unit,
  input  logic                              flush_valid,
  input  logic                              flush_all,
  input  logic [TAG_WIDTH-1:0]              flush_head,
  input  logic [TAG_WIDTH-1:0]              flush_tail,
  output logic [2:0]                        free_count
);

  unit_state_e           state      [NUM_UNITS];
  logic [NUM_UNITS-1:0]  unit_grant;
  logic [NUM_UNITS-1:0]  unit_accept;
  logic [NUM_UNITS-1:0]  unit_rel;
  logic [NUM_UNITS-1:0]  acc_is_div;
  rounding_mode_t        acc_rm     [NUM_UNITS];
  logic [DATA_WIDTH-1:0] acc_opa    [NUM_UNITS];
  logic [DATA_WIDTH-1:0] acc_opb    [NUM_UNITS];
  logic [TAG_WIDTH-1:0]  acc_tag    [NUM_UNITS];
  logic [2:0]            free_now;

  // Grant: lanes in ascending order each take the lowest free, untaken unit.
  always_comb begin
    rsv_gnt    = '0;
    rsv_unit   = '0;
    unit_grant = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (rsv_req[i] && !stall) begin
        for (int u = 0; u < NUM_UNITS; u++) begin
          if (!rsv_gnt[i] && state[u] == UNIT_FREE && !unit_grant[u]) begin
            rsv_gnt[i]                             = 1'b1;
            rsv_unit[i*UNIT_IDX_W +: UNIT_IDX_W]   = unit_idx_t'(u);
            unit_grant[u]                          = 1'b1;
          end
        end
      end
    end
  end

  // Accept: the lowest lane aimed at a RESERVED unit wins; flush_all blocks it.
  always_comb begin
    req_ack     = '0;
    unit_accept = '0;
    acc_is_div  = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      acc_rm[u]  = '0;
      acc_opa[u] = '0;
      acc_opb[u] = '0;
      acc_tag[u] = '0;
    end
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (req_valid[i] && !stall && !(flush_valid && flush_all)) begin
        for (int u = 0; u < NUM_UNITS; u++) begin
          if (req_unit[i*UNIT_IDX_W +: UNIT_IDX_W] == unit_idx_t'(u) &&
              state[u] == UNIT_RESERVED && !unit_accept[u]) begin
            req_ack[i]     = 1'b1;
            unit_accept[u] = 1'b1;
            acc_is_div[u]  = req_is_div[i];
            acc_rm[u]      = req_rm[i*RM_W +: RM_W];
            acc_opa[u]     = req_opa[i*DATA_WIDTH +: DATA_WIDTH];
            acc_opb[u]     = req_opb[i*DATA_WIDTH +: DATA_WIDTH];
            acc_tag[u]     = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
          end
        end
      end
    end
  end

  // Release: any lane may free the unit it names; the slot ignores it unless FINISHED.
  always_comb begin
    unit_rel = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (rel[i] && !stall && rel_unit[i*UNIT_IDX_W +: UNIT_IDX_W] == unit_idx_t'(u))
          unit_rel[u] = 1'b1;
      end
    end
  end

  // Count of units currently FREE, registered below.
  always_comb begin
    free_now = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (state[u] == UNIT_FREE) free_now = free_now + 3'd1;
    end
  end

  // Free-unit count lags the slot states by one cycle.
  always_ff @(posedge clk) begin
    if (rst) free_count <= 3'(NUM_UNITS);
    else     free_count <= free_now;
  end

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_slot
    fp_divsqrt_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .grant       (unit_grant[g]),
      .accept      (unit_accept[g]),
      .is_div      (acc_is_div[g]),
      .rm          (acc_rm[g]),
      .opa         (acc_opa[g]),
      .opb         (acc_opb[g]),
      .tag         (acc_tag[g]),
      .done        (u_done[g]),
      .result      (u_result[g*DATA_WIDTH +: DATA_WIDTH]),
      .fflags      (u_fflags[g*FFLAGS_W +: FFLAGS_W]),
      .rel_hit     (unit_rel[g]),
      .flush_valid (flush_valid),
      .flush_all   (flush_all),
      .flush_head  (flush_head),
      .flush_tail  (flush_tail),
      .state       (state[g]),
      .start       (u_start[g]),
      .kill        (u_kill[g]),
      .fin         (fin[g]),
      .fin_data    (fin_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .fin_fflags  (fin_fflags[g*FFLAGS_W +: FFLAGS_W]),
      .op_is_div   (u_is_div[g]),
      .op_rm       (u_rm[g*RM_W +: RM_W]),
      .op_a        (u_opa[g*DATA_WIDTH +: DATA_WIDTH]),
      .op_b        (u_opb[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_fp_divsqrt_pool_ctrl.sv
// Self-checking bench for fp_divsqrt_pool_ctrl: directed scenarios plus a
// randomized run against a behavioural model of the unit pool.
module tb_fp_divsqrt_pool_ctrl;

  localparam int IW = 2;
  localparam int NU = 2;
  localparam int DW = 32;
  localparam int TW = 6;

  localparam int M_FREE = 0;
  localparam int M_RSV  = 1;
  localparam int M_BUSY = 2;
  localparam int M_FIN  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, stall;
  logic [IW-1:0]    rsv_req, rsv_gnt;
  logic [IW*2-1:0]  rsv_unit;
  logic [IW-1:0]    req_valid;
  logic [IW*2-1:0]  req_unit;
  logic [IW*TW-1:0] req_tag;
  logic [IW-1:0]    req_is_div;
  logic [IW*3-1:0]  req_rm;
  logic [IW*DW-1:0] req_opa, req_opb;
  logic [IW-1:0]    req_ack;
  logic [NU-1:0]    u_start, u_is_div, u_kill, u_done, fin;
  logic [NU*3-1:0]  u_rm;
  logic [NU*DW-1:0] u_opa, u_opb, u_result, fin_data;
  logic [NU*5-1:0]  u_fflags, fin_fflags;
  logic [IW-1:0]    rel;
  logic [IW*2-1:0]  rel_unit;
  logic             flush_valid, flush_all;
  logic [TW-1:0]    flush_head, flush_tail;
  logic [2:0]       free_count;

  int total = 0;
  int bad   = 0;

  fp_divsqrt_pool_ctrl #(
    .ISSUE_WIDTH(IW), .NUM_UNITS(NU), .DATA_WIDTH(DW), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .rsv_req(rsv_req), .rsv_gnt(rsv_gnt), .rsv_unit(rsv_unit),
    .req_valid(req_valid), .req_unit(req_unit), .req_tag(req_tag),
    .req_is_div(req_is_div), .req_rm(req_rm), .req_opa(req_opa), .req_opb(req_opb),
    .req_ack(req_ack),
    .u_start(u_start), .u_is_div(u_is_div), .u_rm(u_rm), .u_opa(u_opa), .u_opb(u_opb),
    .u_kill(u_kill), .u_done(u_done), .u_result(u_result), .u_fflags(u_fflags),
    .fin(fin), .fin_data(fin_data), .fin_fflags(fin_fflags),
    .rel(rel), .rel_unit(rel_unit),
    .flush_valid(flush_valid), .flush_all(flush_all),
    .flush_head(flush_head), .flush_tail(flush_tail),
    .free_count(free_count)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; rsv_req = '0; req_valid = '0; req_unit = '0; req_tag = '0;
    req_is_div = '0; req_rm = '0; req_opa = '0; req_opb = '0;
    u_done = '0; u_result = '0; u_fflags = '0; rel = '0; rel_unit = '0;
    flush_valid = 0; flush_all = 0; flush_head = '0; flush_tail = '0;
  endtask

  // Circular window membership via modular distance from head.
  function automatic bit in_window(bit all, int tag, int head, int tail);
    int m;
    m = (1 << TW) - 1;
    return all || (((tag - head) & m) < ((tail - head) & m));
  endfunction

  task automatic test_reset();
    idle(); rst = 1; cyc(); cyc();
    total++; if (free_count !== 3'd2) begin bad++; $display("FAIL reset_free_count got %0d want 2", free_count); end
    total++; if (fin !== 2'b00) begin bad++; $display("FAIL reset_fin got %b want 00", fin); end
    total++; if (u_start !== 2'b00) begin bad++; $display("FAIL reset_u_start got %b want 00", u_start); end
    total++; if (u_kill !== 2'b00) begin bad++; $display("FAIL reset_u_kill got %b want 00", u_kill); end
    total++; if (u_opa !== '0) begin bad++; $display("FAIL reset_u_opa got %h want 0", u_opa); end
    rst = 0; cyc();
  endtask

  task automatic test_basic_flow();
    idle(); rsv_req = 2'b01; #1;
    total++; if (rsv_gnt !== 2'b01) begin bad++; $display("FAIL basic_gnt got %b want 01", rsv_gnt); end
    total++; if (rsv_unit[1:0] !== 2'd0) begin bad++; $display("FAIL basic_rsv_unit got %0d want 0", rsv_unit[1:0]); end
    cyc(); idle();
    req_valid = 2'b01; req_unit = '0; req_tag[5:0] = 6'd5; req_is_div[0] = 1'b1; req_rm[2:0] = 3'd1;
    req_opa[31:0] = 32'h40800000; req_opb[31:0] = 32'h40000000; #1;
    total++; if (req_ack !== 2'b01) begin bad++; $display("FAIL basic_ack got %b want 01", req_ack); end
    total++; if (free_count !== 3'd2) begin bad++; $display("FAIL basic_free_lag got %0d want 2", free_count); end
    cyc(); idle();
    total++; if (u_start !== 2'b01) begin bad++; $display("FAIL basic_start got %b want 01", u_start); end
    total++; if (u_opa[31:0] !== 32'h40800000 || u_opb[31:0] !== 32'h40000000) begin bad++; $display("FAIL basic_operands got %h %h want 40800000 40000000", u_opa[31:0], u_opb[31:0]); end
    total++; if (u_is_div[0] !== 1'b1 || u_rm[2:0] !== 3'd1) begin bad++; $display("FAIL basic_opfields got %b %0d want 1 1", u_is_div[0], u_rm[2:0]); end
    total++; if (free_count !== 3'd1) begin bad++; $display("FAIL basic_free_one got %0d want 1", free_count); end
    cyc();
    total++; if (u_start !== 2'b00) begin bad++; $display("FAIL basic_start_pulse got %b want 00", u_start); end
    u_done = 2'b01; u_result[31:0] = 32'h40000000; u_fflags[4:0] = 5'h01;
    cyc(); idle(); u_result = {2{32'hdeadbeef}};
    total++; if (fin !== 2'b01) begin bad++; $display("FAIL basic_fin got %b want 01", fin); end
    total++; if (fin_data[31:0] !== 32'h40000000 || fin_fflags[4:0] !== 5'h01) begin bad++; $display("FAIL basic_fin_data got %h %h want 40000000 01", fin_data[31:0], fin_fflags[4:0]); end
    cyc();
    total++; if (fin_data[31:0] !== 32'h40000000) begin bad++; $display("FAIL basic_fin_hold got %h want 40000000", fin_data[31:0]); end
    rel = 2'b01; rel_unit = '0;
    cyc(); idle();
    total++; if (fin !== 2'b00) begin bad++; $display("FAIL basic_rel_fin got %b want 00", fin); end
    cyc();
    total++; if (free_count !== 3'd2) begin bad++; $display("FAIL basic_free_back got %0d want 2", free_count); end
  endtask

  task automatic test_contention();
    idle(); rsv_req = 2'b11; #1;
    total++; if (rsv_gnt !== 2'b11) begin bad++; $display("FAIL cont_gnt2 got %b want 11", rsv_gnt); end
    total++; if (rsv_unit !== 4'b0100) begin bad++; $display("FAIL cont_units got %b want 0100", rsv_unit); end
    cyc(); idle();
    req_valid = 2'b11; req_unit = 4'b0000; #1;
    total++; if (req_ack !== 2'b01) begin bad++; $display("FAIL cont_same_unit_ack got %b want 01", req_ack); end
    req_unit = 4'b0100; #1;
    total++; if (req_ack !== 2'b11) begin bad++; $display("FAIL cont_both_ack got %b want 11", req_ack); end
    flush_valid = 1; flush_all = 1; #1;
    total++; if (req_ack !== 2'b00) begin bad++; $display("FAIL cont_flush_blocks_ack got %b want 00", req_ack); end
    cyc(); idle();
    rsv_req = 2'b01; cyc(); idle();
    rsv_req = 2'b11; #1;
    total++; if (rsv_gnt !== 2'b01 || rsv_unit[1:0] !== 2'd1) begin bad++; $display("FAIL cont_gnt1 got %b unit %0d want 01 unit 1", rsv_gnt, rsv_unit[1:0]); end
    cyc(); idle();
    flush_valid = 1; flush_all = 1; cyc(); idle(); cyc();
    total++; if (free_count !== 3'd2) begin bad++; $display("FAIL cont_flush_all_free got %0d want 2", free_count); end
  endtask

  task automatic test_wrap_flush();
    idle(); rsv_req = 2'b11; cyc(); idle();
    req_valid = 2'b11; req_unit = 4'b0100; req_tag = {6'd10, 6'd62};
    cyc(); idle();
    total++; if (u_start !== 2'b11) begin bad++; $display("FAIL wrap_start got %b want 11", u_start); end
    flush_valid = 1; flush_head = 6'd60; flush_tail = 6'd2;
    cyc(); idle();
    total++; if (u_kill !== 2'b01) begin bad++; $display("FAIL wrap_kill got %b want 01", u_kill); end
    cyc();
    total++; if (u_kill !== 2'b00 || free_count !== 3'd1) begin bad++; $display("FAIL wrap_after got kill %b free %0d want 00 1", u_kill, free_count); end
    u_done = 2'b10; u_result[63:32] = 32'h3f800000;
    cyc(); idle();
    total++; if (fin !== 2'b10 || fin_data[63:32] !== 32'h3f800000) begin bad++; $display("FAIL wrap_survivor got %b %h want 10 3f800000", fin, fin_data[63:32]); end
    rel = 2'b10; rel_unit = 4'b0100;
    cyc(); idle();
    total++; if (fin !== 2'b00) begin bad++; $display("FAIL wrap_release got %b want 00", fin); end
    cyc();
  endtask

  task automatic test_flush_done_collision();
    idle(); rsv_req = 2'b01; cyc(); idle();
    req_valid = 2'b01; req_tag[5:0] = 6'd20; cyc(); idle();
    u_done = 2'b01; u_result[31:0] = 32'h12345678; flush_valid = 1; flush_head = 6'd15; flush_tail = 6'd25;
    cyc(); idle();
    total++; if (fin !== 2'b00 || u_kill !== 2'b01) begin bad++; $display("FAIL collide got fin %b kill %b want 00 01", fin, u_kill); end
    cyc();
    total++; if (free_count !== 3'd2) begin bad++; $display("FAIL collide_free got %0d want 2", free_count); end
  endtask

  task automatic test_stall();
    idle(); rsv_req = 2'b11; cyc(); idle();
    req_valid = 2'b01; req_tag[5:0] = 6'd7; cyc(); idle();
    stall = 1; rsv_req = 2'b11; req_valid = 2'b10; req_unit = 4'b0100;
    u_done = 2'b01; u_result[31:0] = 32'h40400000; #1;
    total++; if (rsv_gnt !== 2'b00 || req_ack !== 2'b00) begin bad++; $display("FAIL stall_gnt_ack got %b %b want 00 00", rsv_gnt, req_ack); end
    cyc(); u_done = '0; rel = 2'b01; rel_unit = '0; #1;
    total++; if (fin !== 2'b01 || fin_data[31:0] !== 32'h40400000) begin bad++; $display("FAIL stall_done_captured got %b %h want 01 40400000", fin, fin_data[31:0]); end
    total++; if (req_ack !== 2'b00 || u_start !== 2'b00) begin bad++; $display("FAIL stall_no_accept got ack %b start %b want 00 00", req_ack, u_start); end
    cyc();
    total++; if (fin !== 2'b01 || u_start !== 2'b00 || free_count !== 3'd0) begin bad++; $display("FAIL stall_frozen got fin %b start %b free %0d want 01 00 0", fin, u_start, free_count); end
    idle(); rel = 2'b01; rel_unit = '0; cyc(); idle();
    total++; if (fin !== 2'b00) begin bad++; $display("FAIL stall_release_after got %b want 00", fin); end
    flush_valid = 1; flush_all = 1; cyc(); idle(); cyc();
    total++; if (free_count !== 3'd2) begin bad++; $display("FAIL stall_cleanup got %0d want 2", free_count); end
  endtask

  task automatic test_reset_busy();
    idle(); rsv_req = 2'b01; cyc(); idle();
    req_valid = 2'b01; req_tag[5:0] = 6'd3; cyc(); idle();
    rst = 1; cyc(); rst = 0;
    total++; if (fin !== 2'b00 || u_start !== 2'b00 || u_kill !== 2'b00) begin bad++; $display("FAIL rstbusy_outputs got %b %b %b want 00 00 00", fin, u_start, u_kill); end
    total++; if (free_count !== 3'd2) begin bad++; $display("FAIL rstbusy_free got %0d want 2", free_count); end
    rsv_req = 2'b11; #1;
    total++; if (rsv_gnt !== 2'b11) begin bad++; $display("FAIL rstbusy_grantable got %b want 11", rsv_gnt); end
    idle(); cyc();
  endtask

  task automatic test_random();
    int            mst [NU];
    logic [TW-1:0] mtag [NU];
    logic [DW-1:0] mdata [NU];
    logic [DW-1:0] mopa [NU];
    logic [4:0]    mfl [NU];
    int            lane_of [NU];
    int            free_q [$];
    logic [IW-1:0] eg, ea;
    logic [IW*2-1:0] eu;
    logic [NU-1:0] mgr, macc, es, ek, ef;
    int            nfree, t;
    bit            hit, relhit;
    idle(); rst = 1; cyc(); rst = 0;
    for (int u = 0; u < NU; u++) begin
      mst[u] = M_FREE; mtag[u] = '0; mdata[u] = '0; mopa[u] = '0; mfl[u] = '0; lane_of[u] = 0;
    end
    repeat (400) begin
      stall = ($urandom_range(4) == 0);
      rsv_req = IW'($urandom); req_valid = IW'($urandom); req_tag = (IW*TW)'($urandom);
      req_is_div = IW'($urandom); req_rm = (IW*3)'($urandom);
      req_opa = {$urandom, $urandom}; req_opb = {$urandom, $urandom};
      rel = IW'($urandom);
      for (int i = 0; i < IW; i++) begin
        req_unit[i*2 +: 2] = ($urandom_range(7) == 0) ? 2'd3 : 2'($urandom_range(NU-1));
        rel_unit[i*2 +: 2] = 2'($urandom_range(NU-1));
      end
      for (int u = 0; u < NU; u++) u_done[u] = (mst[u] == M_BUSY) && ($urandom_range(2) == 0);
      u_result = {$urandom, $urandom}; u_fflags = (NU*5)'($urandom);
      flush_valid = ($urandom_range(5) == 0); flush_all = ($urandom_range(2) == 0);
      flush_head = TW'($urandom); flush_tail = TW'($urandom);
      #1;
      free_q.delete(); nfree = 0;
      for (int u = 0; u < NU; u++) if (mst[u] == M_FREE) begin free_q.push_back(u); nfree++; end
      eg = '0; eu = '0; mgr = '0;
      for (int i = 0; i < IW; i++) begin
        if (rsv_req[i] && !stall && free_q.size() > 0) begin
          t = free_q.pop_front(); eg[i] = 1'b1; eu[i*2 +: 2] = 2'(t); mgr[t] = 1'b1;
        end
      end
      ea = '0; macc = '0;
      for (int i = 0; i < IW; i++) begin
        t = int'(req_unit[i*2 +: 2]);
        if (req_valid[i] && !stall && !(flush_valid && flush_all) && t < NU) begin
          if (mst[t] == M_RSV && !macc[t]) begin ea[i] = 1'b1; macc[t] = 1'b1; lane_of[t] = i; end
        end
      end
      total++; if (rsv_gnt !== eg || rsv_unit !== eu) begin bad++; $display("FAIL rand_grant got %b/%b want %b/%b", rsv_gnt, rsv_unit, eg, eu); end
      total++; if (req_ack !== ea) begin bad++; $display("FAIL rand_ack got %b want %b", req_ack, ea); end
      es = '0; ek = '0;
      for (int u = 0; u < NU; u++) begin
        hit = flush_valid && in_window(flush_all, int'(mtag[u]), int'(flush_head), int'(flush_tail));
        relhit = 0;
        for (int i = 0; i < IW; i++) if (rel[i] && !stall && int'(rel_unit[i*2 +: 2]) == u) relhit = 1;
        case (mst[u])
          M_FREE: if (mgr[u]) mst[u] = M_RSV;
          M_RSV: begin
            if (flush_valid && flush_all) mst[u] = M_FREE;
            else if (macc[u]) begin
              mst[u] = M_BUSY; es[u] = 1'b1;
              mtag[u] = req_tag[lane_of[u]*TW +: TW];
              mopa[u] = req_opa[lane_of[u]*DW +: DW];
            end
          end
          M_BUSY: begin
            if (hit) begin mst[u] = M_FREE; ek[u] = 1'b1; end
            else if (u_done[u]) begin
              mst[u] = M_FIN; mdata[u] = u_result[u*DW +: DW]; mfl[u] = u_fflags[u*5 +: 5];
            end
          end
          default: if (hit || relhit) mst[u] = M_FREE;
        endcase
      end
      ef = '0;
      for (int u = 0; u < NU; u++) ef[u] = (mst[u] == M_FIN);
      cyc();
      total++; if (u_start !== es || u_kill !== ek) begin bad++; $display("FAIL rand_pulses got start %b kill %b want %b %b", u_start, u_kill, es, ek); end
      total++; if (fin !== ef) begin bad++; $display("FAIL rand_fin got %b want %b", fin, ef); end
      total++; if (free_count !== 3'(nfree)) begin bad++; $display("FAIL rand_free_count got %0d want %0d", free_count, nfree); end
      for (int u = 0; u < NU; u++) begin
        if (ef[u]) begin
          total++; if (fin_data[u*DW +: DW] !== mdata[u] || fin_fflags[u*5 +: 5] !== mfl[u]) begin bad++; $display("FAIL rand_fin_data unit %0d got %h/%h want %h/%h", u, fin_data[u*DW +: DW], fin_fflags[u*5 +: 5], mdata[u], mfl[u]); end
        end
        if (es[u]) begin
          total++; if (u_opa[u*DW +: DW] !== mopa[u]) begin bad++; $display("FAIL rand_opa unit %0d got %h want %h", u, u_opa[u*DW +: DW], mopa[u]); end
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1; idle();
    test_reset();
    test_basic_flow();
    test_contention();
    test_wrap_flush();
    test_flush_done_collision();
    test_stall();
    test_reset_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
